uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/UART_Types.sv | 31 +++
 rtl/uart_sync.sv | 22 ++
 rtl/uart_rx.sv | 147 ++++++++++++++
 tb/tb_uart_rx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/UART_Types.sv
// Shared UART configuration types, used by the receiver and the other UART blocks.
`default_nettype none
package UART_Types;

  typedef enum logic [1:0] {
    Parity_NONE = 2'd0,
    Parity_EVEN = 2'd1,
    Parity_ODD  = 2'd2
  } Parity;

  typedef enum logic {
    StopBits_1 = 1'b0,
    StopBits_2 = 1'b1
  } StopBits;

  typedef enum logic [1:0] {
    DataBits_5 = 2'd0,
    DataBits_6 = 2'd1,
    DataBits_7 = 2'd2,
    DataBits_8 = 2'd3
  } DataBits;

  // Index of the final data bit: 5 bits -> 4, up to 8 bits -> 7.
  function automatic logic [2:0] last_bit_idx(DataBits db);
    logic [1:0] v;
    v = db;
    return {1'b1, v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync.sv
// Two-flop synchronizer for asynchronous single-bit inputs; reset level is a parameter.
`default_nettype none
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] sync_q;

  always_ff @(posedge i_clock) begin
    if (!i_reset) sync_q <= {2{RESET_VAL}};
    else          sync_q <= {sync_q[0], i_d};
  end

  assign o_q = sync_q[1];

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 5-8 data bits, optional parity, 1 or 2 stop bits.
`default_nettype none
module uart_rx
  import UART_Types::*;
(
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_rx,
  input  logic       i_ce,
  input  Parity      i_parity,
  input  StopBits    i_stopBits,
  input  DataBits    i_dataBits,
  input  logic       i_re,
  output logic [7:0] o_data,
  output logic       o_rdy,
  output logic       o_parityErr,
  output logic       o_frameErr,
  output logic       o_overrun,
  output logic       o_busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } state_t;

  state_t     state_q;
  logic [3:0] tick_q;
  logic [2:0] bit_q;
  logic [7:0] shift_q;
  logic       par_q;
  logic       frame_q;
  logic       rxs;

  uart_sync #(.RESET_VAL(1'b1)) u_sync (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_d     (i_rx),
    .o_q     (rxs)
  );

  logic [7:0] shift_d;
  logic       frame_d;
  logic       par_exp;
  logic       sample;
  logic       done;

  assign shift_d = {shift_q[6:0], rxs};
  assign frame_d = frame_q | ~rxs;
  // Upper shift bits are cleared at frame start, so the full XOR covers only data bits.
  assign par_exp = (i_parity == Parity_ODD) ? ~(^shift_q) : ^shift_q;
  assign sample  = (tick_q == 4'd15);
  assign done    = i_ce && sample &&
                   ((state_q == STOP1 && i_stopBits == StopBits_1) || state_q == STOP2);

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q     <= IDLE;
      tick_q      <= 4'd0;
      bit_q       <= 3'd0;
      shift_q     <= 8'h00;
      par_q       <= 1'b0;
      frame_q     <= 1'b0;
      o_data      <= 8'h00;
      o_rdy       <= 1'b0;
      o_parityErr <= 1'b0;
      o_frameErr  <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      if (i_re && o_rdy) begin
        o_rdy     <= 1'b0;
        o_overrun <= 1'b0;
      end
      if (i_ce) begin
        case (state_q)
          IDLE: begin
            if (!rxs) begin
              state_q <= START;
              tick_q  <= 4'd0;
            end
          end
          START: begin
            if (tick_q == 4'd7) begin
              tick_q  <= 4'd0;
              bit_q   <= 3'd0;
              shift_q <= 8'h00;
              par_q   <= 1'b0;
              frame_q <= 1'b0;
              state_q <= rxs ? IDLE : DATA;
            end else begin
              tick_q <= tick_q + 4'd1;
            end
          end
          DATA: begin
            if (sample) begin
              tick_q  <= 4'd0;
              shift_q <= shift_d;
              if (bit_q == last_bit_idx(i_dataBits)) begin
                state_q <= (i_parity != Parity_NONE) ? PARITY : STOP1;
              end else begin
                bit_q <= bit_q + 3'd1;
              end
            end else begin
              tick_q <= tick_q + 4'd1;
            end
          end
          PARITY: begin
            if (sample) begin
              tick_q  <= 4'd0;
              par_q   <= (rxs != par_exp);
              state_q <= STOP1;
            end else begin
              tick_q <= tick_q + 4'd1;
            end
          end
          STOP1, STOP2: begin
            if (sample) begin
              tick_q  <= 4'd0;
              frame_q <= frame_d;
              if (state_q == STOP1 && i_stopBits == StopBits_2) state_q <= STOP2;
            end else begin
              tick_q <= tick_q + 4'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
      // Completion overrides the acknowledge above so a word arriving with i_re lands valid.
      if (done) begin
        state_q     <= IDLE;
        o_data      <= shift_q;
        o_parityErr <= par_q;
        o_frameErr  <= frame_d;
        o_rdy       <= 1'b1;
        if (o_rdy && !i_re) o_overrun <= 1'b1;
      end
    end
  end

  assign o_busy = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of frames plus hand sequences for timing corner cases.
`default_nettype none
module tb_uart_rx;
  import UART_Types::*;

  logic       clk = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_rx = 1'b1;
  logic       i_ce;
  Parity      i_parity = Parity_NONE;
  StopBits    i_stopBits = StopBits_1;
  DataBits    i_dataBits = DataBits_8;
  logic       i_re = 1'b0;
  logic [7:0] o_data;
  logic       o_rdy, o_parityErr, o_frameErr, o_overrun, o_busy;

  uart_rx dut (
    .i_clock     (clk),
    .i_reset     (i_reset),
    .i_rx        (i_rx),
    .i_ce        (i_ce),
    .i_parity    (i_parity),
    .i_stopBits  (i_stopBits),
    .i_dataBits  (i_dataBits),
    .i_re        (i_re),
    .o_data      (o_data),
    .o_rdy       (o_rdy),
    .o_parityErr (o_parityErr),
    .o_frameErr  (o_frameErr),
    .o_overrun   (o_overrun),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  logic [1:0] ce_div = 2'd0;
  int tick_no = 0;
  always @(posedge clk) begin
    ce_div <= ce_div + 2'd1;
    if (i_ce) tick_no <= tick_no + 1;
  end
  assign i_ce = (ce_div == 2'd3);

  int  checks = 0;
  int  errors = 0;
  int  last_start = 0;
  int  rise_tick = 0;
  int  lat = 0;
  bit  rdy_prev = 1'b0;
  bit  busy_seen = 1'b0;

  always @(posedge clk) begin
    #1;
    if (o_rdy && !rdy_prev) rise_tick = tick_no;
    rdy_prev = o_rdy;
    if (o_busy) busy_seen = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance past n oversample ticks; returns 1 time unit after the last ticking edge.
  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      do @(negedge clk); while (!i_ce);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input DataBits nb, input Parity par,
                            input StopBits sb, input bit flip, input logic [1:0] stop_low);
    int n;
    logic [7:0] m;
    logic p;
    n = 5 + int'(nb);
    m = data & (8'hFF >> (8 - n));
    i_dataBits = nb;
    i_parity   = par;
    i_stopBits = sb;
    wait_ticks(1);
    i_rx = 1'b0;
    last_start = tick_no;
    wait_ticks(16);
    for (int k = n - 1; k >= 0; k--) begin
      i_rx = m[k];
      wait_ticks(16);
    end
    if (par != Parity_NONE) begin
      p = ^m;
      if (par == Parity_ODD) p = ~p;
      if (flip) p = ~p;
      i_rx = p;
      wait_ticks(16);
    end
    i_rx = ~stop_low[0];
    wait_ticks(16);
    if (sb == StopBits_2) begin
      i_rx = ~stop_low[1];
      wait_ticks(16);
    end
    i_rx = 1'b1;
    wait_ticks(20);
  endtask

  task automatic ack();
    @(negedge clk);
    i_re = 1'b1;
    @(posedge clk);
    #1;
    i_re = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    DataBits    nb;
    Parity      par;
    StopBits    sb;
    bit         flip;
    logic [1:0] stop_low;
    logic [7:0] exp_data;
    bit         exp_perr;
    bit         exp_ferr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'hA5, DataBits_8, Parity_NONE, StopBits_1, 1'b0, 2'b00, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h2B, DataBits_7, Parity_EVEN, StopBits_2, 1'b0, 2'b00, 8'h2B, 1'b0, 1'b0};
    vecs[2] = '{8'h2B, DataBits_7, Parity_EVEN, StopBits_2, 1'b1, 2'b00, 8'h2B, 1'b1, 1'b0};
    vecs[3] = '{8'h55, DataBits_8, Parity_NONE, StopBits_1, 1'b0, 2'b01, 8'h55, 1'b0, 1'b1};
    vecs[4] = '{8'h13, DataBits_5, Parity_ODD,  StopBits_1, 1'b0, 2'b00, 8'h13, 1'b0, 1'b0};
    vecs[5] = '{8'h3C, DataBits_6, Parity_NONE, StopBits_2, 1'b0, 2'b00, 8'h3C, 1'b0, 1'b0};
    vecs[6] = '{8'h81, DataBits_8, Parity_EVEN, StopBits_2, 1'b0, 2'b10, 8'h81, 1'b0, 1'b1};
    vecs[7] = '{8'hFA, DataBits_5, Parity_NONE, StopBits_1, 1'b0, 2'b00, 8'h1A, 1'b0, 1'b0};

    repeat (4) @(posedge clk);
    #1;
    chk("reset o_data", o_data, 8'h00);
    chk("reset o_rdy", o_rdy, 1'b0);
    chk("reset o_busy", o_busy, 1'b0);
    chk("reset o_overrun", o_overrun, 1'b0);
    @(negedge clk);
    i_reset = 1'b1;
    wait_ticks(4);

    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].data, vecs[i].nb, vecs[i].par, vecs[i].sb, vecs[i].flip, vecs[i].stop_low);
      chk($sformatf("v%0d o_rdy", i), o_rdy, 1'b1);
      chk($sformatf("v%0d o_data", i), o_data, vecs[i].exp_data);
      chk($sformatf("v%0d o_parityErr", i), o_parityErr, vecs[i].exp_perr);
      chk($sformatf("v%0d o_frameErr", i), o_frameErr, vecs[i].exp_ferr);
      chk($sformatf("v%0d o_overrun", i), o_overrun, 1'b0);
      chk($sformatf("v%0d o_busy", i), o_busy, 1'b0);
      if (i == 0) begin
        lat = rise_tick - last_start;
        // Slack of a tick either side for where the edge lands relative to i_ce.
        chk("latency in window", (lat >= 151 && lat <= 153), 1'b1);
      end
      ack();
      chk($sformatf("v%0d ack o_rdy", i), o_rdy, 1'b0);
    end

    // Short low glitch: false start, nothing delivered.
    i_parity = Parity_NONE; i_stopBits = StopBits_1; i_dataBits = DataBits_8;
    wait_ticks(1);
    busy_seen = 1'b0;
    i_rx = 1'b0;
    wait_ticks(5);
    i_rx = 1'b1;
    wait_ticks(20);
    chk("glitch busy pulse", busy_seen, 1'b1);
    chk("glitch o_busy", o_busy, 1'b0);
    chk("glitch o_rdy", o_rdy, 1'b0);

    // Two frames without reading: overrun.
    send_frame(8'h11, DataBits_8, Parity_NONE, StopBits_1, 1'b0, 2'b00);
    chk("ovr first o_overrun", o_overrun, 1'b0);
    send_frame(8'h22, DataBits_8, Parity_NONE, StopBits_1, 1'b0, 2'b00);
    chk("ovr o_data", o_data, 8'h22);
    chk("ovr o_rdy", o_rdy, 1'b1);
    chk("ovr o_overrun", o_overrun, 1'b1);
    ack();
    chk("ovr ack o_rdy", o_rdy, 1'b0);
    chk("ovr ack o_overrun", o_overrun, 1'b0);

    // Read strobe coinciding with completion of the next word.
    send_frame(8'h11, DataBits_8, Parity_NONE, StopBits_1, 1'b0, 2'b00);
    fork
      send_frame(8'h77, DataBits_8, Parity_NONE, StopBits_1, 1'b0, 2'b00);
      begin
        int guard;
        guard = 0;
        wait_ticks(40);
        do begin
          @(negedge clk);
          guard++;
        end while (!(i_ce && (tick_no + 1 == last_start + lat)) && guard < 4000);
        chk("coincident re timeout", guard < 4000, 1'b1);
        i_re = 1'b1;
        @(posedge clk);
        #1;
        i_re = 1'b0;
      end
    join
    chk("coincident o_rdy", o_rdy, 1'b1);
    chk("coincident o_data", o_data, 8'h77);
    chk("coincident o_overrun", o_overrun, 1'b0);

    // Reset during data bit 4 while a word is still pending.
    wait_ticks(1);
    i_rx = 1'b0;
    wait_ticks(16);
    i_rx = 1'b1;
    wait_ticks(16 * 4 + 8);
    @(negedge clk);
    i_reset = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset o_data", o_data, 8'h00);
    chk("midreset o_rdy", o_rdy, 1'b0);
    chk("midreset o_parityErr", o_parityErr, 1'b0);
    chk("midreset o_frameErr", o_frameErr, 1'b0);
    chk("midreset o_overrun", o_overrun, 1'b0);
    chk("midreset o_busy", o_busy, 1'b0);
    @(negedge clk);
    i_reset = 1'b1;
    wait_ticks(40);
    chk("post reset idle o_rdy", o_rdy, 1'b0);
    chk("post reset idle o_busy", o_busy, 1'b0);
    send_frame(8'hC3, DataBits_8, Parity_NONE, StopBits_1, 1'b0, 2'b00);
    chk("after reset o_data", o_data, 8'hC3);
    chk("after reset o_rdy", o_rdy, 1'b1);
    chk("after reset o_frameErr", o_frameErr, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000000;
    errors++;
    $display("FAIL global timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
`default_nettype wire
